grayscale_stream_gen: RTL
=========================

// Module: grayscale_stream_gen
// PURPOSE
//  Video source. Emits an 8-bit grayscale raster stream with HDMI-style timing
//  (hdmi_vs, hdmi_hs, hdmi_de, grayscale_data) on hdmi_clk.
//  Pixels are pulled from an upstream buffer over a valid/ready handshake.
//  Drives the disparity pipeline and the PGM capture bench from stored images.
// PARAMETERS
//  HR      800  active pixels per line
//  VR      300  active lines per frame
//  H_SYNC  40   hsync width, clocks
//  H_BP    20   h back porch, clocks
//  H_FP    20   h front porch, clocks
//  V_SYNC  2    vsync width, lines
//  V_BP    5    v back porch, lines
//  V_FP    5    v front porch, lines
// PORTS
//  hdmi_clk        in   1  pixel clock; all logic on posedge
//  rst_n           in   1  reset; asynchronous assert, active-low
//  enable          in   1  run request; sampled only at frame boundary
//  pix_data        in   8  upstream pixel
//  pix_valid       in   1  pix_data valid
//  pix_ready       out  1  pixel consumed this cycle (pix_valid & pix_ready)
//  hdmi_vs         out  1  vsync, active-high
//  hdmi_hs         out  1  hsync, active-high
//  hdmi_de         out  1  active-video enable
//  grayscale_data  out  8  pixel; 0x00 when hdmi_de=0
//  frame_start     out  1  1-clock pulse with first hdmi_vs=1 of each frame
//  underrun        out  1  sticky; set when pix_ready=1 and pix_valid=0
//  frame_count     out  8  frames started since reset; wraps 255->0
// BEHAVIOUR
//  - Counters h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
//    H_TOTAL=H_SYNC+H_BP+HR+H_FP; V_TOTAL=V_SYNC+V_BP+VR+V_FP.
//  - Line order: sync, back porch, active, front porch. Frame order: sync lines, bp, active, fp.
//  - States: IDLE (counters 0, outputs low) -> RUN.
//    IDLE->RUN when enable=1. At h=H_TOTAL-1,v=V_TOTAL-1: enable=1 wraps to (0,0); else IDLE.
//    Deasserting enable mid-frame completes the frame.
//  - hs=(h<H_SYNC); vs=(v<V_SYNC); de=h,v both in active region.
//    All outputs are registered: 1 clock latency from counter state.
//  - pix_ready is combinational = RUN & active(h,v); the matching pixel appears on
//    grayscale_data with hdmi_de in the next clock.
//  - Underrun: ready & !valid -> hdmi_de still 1, grayscale_data=0x00, underrun set.
//    Timing is never stalled. underrun clears only on reset.
//  - frame_start and frame_count increment on the clock hdmi_vs first rises.
//  - Reset (any time, incl. mid-frame): outputs 0, counters 0, state IDLE, underrun 0.
//  - Exactly HR*VR pixels are consumed per frame; pix_valid outside ready is ignored.
// CONFIGURATION
//  TEST_PATTERN_EN defined: extra input pattern_sel (1 bit), sampled at frame boundary.
//    When 1: pix_ready held 0, underrun not updated.
//    grayscale_data=(x+y+frame_count)[7:0]; x,y = active column/row from 0.
//  Undefined: no pattern_sel port; data always from pix_data.
// TESTING  (HR=4,VR=2,H_SYNC=2,H_BP=1,H_FP=1,V_SYNC=1,V_BP=1,V_FP=1; H_TOTAL=8,V_TOTAL=5)
//  1 rst_n=0->1, enable=1, pix_valid=1, pix_data=ramp 0,1,2..
//    -> vs high 8 clks/frame, hs high 2 of 8 clks;
//       de in lines 2,3 clks 3..6; data 0..7; 40-clk frame.
//  2 Feed through PGM capture bench, 3 frames -> each file has 8 px and header "P5\n4 2\n255\n".
//  3 pix_valid=0 on 3rd ready -> that pixel 0x00, underrun=1 and stays, timing unchanged.
//  4 enable=0 at clk 10 of frame -> frame completes all 8 px, then IDLE; vs,hs,de=0.
//  5 rst_n=0 during active video -> all outputs 0 asynchronously.
//    On release: restarts at frame top, frame_count=1 after first vs.
//  6 TEST_PATTERN_EN, pattern_sel=1, frame_count=2 -> row0 2,3,4,5; row1 3,4,5,6; pix_ready=0.

Source files
------------

// File: rtl/grayscale_stream_gen.sv
// Grayscale raster source with HDMI-style sync/porch timing, fed by a valid/ready pixel stream.
// Optional build macro TEST_PATTERN_EN adds pattern_sel and an internal diagonal-ramp generator.
module grayscale_stream_gen #(
   parameter int HR     = 800,
   parameter int VR     = 300,
   parameter int H_SYNC = 40,
   parameter int H_BP   = 20,
   parameter int H_FP   = 20,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 5,
   parameter int V_FP   = 5
) (
   input  logic       hdmi_clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] pix_data,
   input  logic       pix_valid,
`ifdef TEST_PATTERN_EN
   input  logic       pattern_sel,
`endif
   output logic       pix_ready,
   output logic       hdmi_vs,
   output logic       hdmi_hs,
   output logic       hdmi_de,
   output logic [7:0] grayscale_data,
   output logic       frame_start,
   output logic       underrun,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_SYNC + H_BP + HR + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + VR + V_FP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_SYNC + H_BP + HR - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_SYNC + V_BP + VR - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_next;
   logic [HW-1:0] h, h_next;
   logic [VW-1:0] v, v_next;
   logic          running, active, frame_top, frame_end;
   logic [7:0]    pixel;

   assign running   = (state == RUN);
   assign active    = running && (h >= H_ACT_BEG) && (h <= H_ACT_LAST)
                              && (v >= V_ACT_BEG) && (v <= V_ACT_LAST);
   assign frame_top = running && (h == '0) && (v == '0);
   assign frame_end = (state == IDLE) || ((h == H_LAST) && (v == V_LAST));

   always_ff @(posedge hdmi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         h     <= '0;
         v     <= '0;
      end else begin
         state <= state_next;
         h     <= h_next;
         v     <= v_next;
      end
   end

   // enable is only consulted while idle or on the last clock of a frame
   always_comb begin
      state_next = state;
      h_next     = h;
      v_next     = v;
      case (state)
         IDLE: begin
            if (enable) state_next = RUN;
         end
         RUN: begin
            if (h == H_LAST) begin
               h_next = '0;
               if (v == V_LAST) begin
                  v_next = '0;
                  if (!enable) state_next = IDLE;
               end else begin
                  v_next = v + 1'b1;
               end
            end else begin
               h_next = h + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef TEST_PATTERN_EN
   logic       pattern_mode;
   logic [7:0] x, y;

   assign x = 8'(h - H_ACT_BEG);
   assign y = 8'(v - V_ACT_BEG);

   always_ff @(posedge hdmi_clk or negedge rst_n) begin
      if (!rst_n) pattern_mode <= 1'b0;
      else if (frame_end) pattern_mode <= pattern_sel;
   end

   assign pix_ready = active && !pattern_mode;

   always_comb begin
      pixel = pix_valid ? pix_data : 8'h00;
      if (pattern_mode) pixel = x + y + frame_count;
   end
`else
   assign pix_ready = active;

   always_comb begin
      pixel = pix_valid ? pix_data : 8'h00;
   end
`endif

   // Timing never stalls: a missing pixel is shown as black and flagged
   always_ff @(posedge hdmi_clk or negedge rst_n) begin
      if (!rst_n) begin
         hdmi_hs        <= 1'b0;
         hdmi_vs        <= 1'b0;
         hdmi_de        <= 1'b0;
         grayscale_data <= 8'h00;
         frame_start    <= 1'b0;
         frame_count    <= 8'h00;
         underrun       <= 1'b0;
      end else begin
         hdmi_hs        <= running && (h < H_SYNC_END);
         hdmi_vs        <= running && (v < V_SYNC_END);
         hdmi_de        <= active;
         grayscale_data <= active ? pixel : 8'h00;
         frame_start    <= frame_top;
         if (frame_top) frame_count <= frame_count + 8'd1;
         if (pix_ready && !pix_valid) underrun <= 1'b1;
      end
   end

endmodule
